vending_machine_change: RTL

//  Parametrised vending FSM. Accepts Rs5/Rs10/Rs20 coins up to a configurable price.

---
 rtl/vending_machine_change_if.sv | 27 ++
 rtl/vending_machine_change.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/vending_machine_change_if.sv
// Coin-acceptor / actuator bundle for vending_machine_change.
// master = coin front end and actuator drivers, slave = vending FSM.
interface vending_machine_change_if #(
  parameter int unsigned CREDIT_W = 6
);
  logic [1:0]          coin_in;
  logic                cancel;
  logic                restock;
  logic                change_ack;
  logic                coin_ready;
  logic                coin_reject;
  logic                dispense;
  logic                change_valid;
  logic [1:0]          change_coin;
  logic [CREDIT_W-1:0] credit;
  logic                sold_out;

  modport master (
    output coin_in, cancel, restock, change_ack,
    input  coin_ready, coin_reject, dispense, change_valid, change_coin, credit, sold_out
  );

  modport slave (
    input  coin_in, cancel, restock, change_ack,
    output coin_ready, coin_reject, dispense, change_valid, change_coin, credit, sold_out
  );
endinterface

// File: rtl/vending_machine_change.sv
// Vending FSM: collects Rs5/10/20 coins, dispenses one item, returns change/refund as a coin stream.
// Optional stock counter enabled by defining VM_STOCK_EN.
module vending_machine_change #(
  parameter int unsigned PRICE      = 15,
  parameter int unsigned MAX_CREDIT = 35,
  parameter int unsigned CREDIT_W   = 6,
  parameter int unsigned STOCK_INIT = 8,
  parameter int unsigned STOCK_W    = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  vending_machine_change_if.slave bus
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic                r_reject, w_reject_nxt;
  logic                r_dispense, w_dispense_nxt;
  logic                r_change_valid, w_change_valid_nxt;
  logic [1:0]          r_change_coin, w_change_coin_nxt;
  logic                w_sold_out;
  logic                w_coin_ready;
  logic                w_coin_present;
  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W-1:0] w_chg_val;
  logic [SUM_W-1:0]    w_sum;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'b01:   return CREDIT_W'(5);
      2'b10:   return CREDIT_W'(10);
      2'b11:   return CREDIT_W'(20);
      default: return CREDIT_W'(0);
    endcase
  endfunction

  // Greedy change: largest denomination not exceeding the remaining credit.
  function automatic logic [1:0] largest_coin(input logic [CREDIT_W-1:0] amt);
    if (amt >= CREDIT_W'(20))      return 2'b11;
    else if (amt >= CREDIT_W'(10)) return 2'b10;
    else if (amt >= CREDIT_W'(5))  return 2'b01;
    else                           return 2'b00;
  endfunction

  always_comb begin
    w_coin_ready       = ((r_state == S_IDLE) || (r_state == S_COLLECT)) && !w_sold_out;
    w_coin_present     = (bus.coin_in != 2'b00);
    w_coin_val         = coin_value(bus.coin_in);
    w_sum              = SUM_W'(r_credit) + SUM_W'(w_coin_val);
    w_chg_val          = coin_value(r_change_coin);
    w_state_nxt        = r_state;
    w_credit_nxt       = r_credit;
    w_reject_nxt       = w_coin_present && !w_coin_ready;
    w_dispense_nxt     = 1'b0;

    case (r_state)
      S_IDLE, S_COLLECT: begin
        // Cancel outranks a coin arriving in the same cycle.
        if ((r_state == S_COLLECT) && bus.cancel) begin
          w_state_nxt  = S_CHANGE;
          w_reject_nxt = w_coin_present;
        end else if (w_coin_ready && w_coin_present) begin
          if (w_sum <= SUM_W'(MAX_CREDIT)) begin
            w_credit_nxt = CREDIT_W'(w_sum);
            if (w_sum >= SUM_W'(PRICE)) begin
              w_state_nxt    = S_VEND;
              w_dispense_nxt = 1'b1;
            end else begin
              w_state_nxt = S_COLLECT;
            end
          end else begin
            w_reject_nxt = 1'b1;
          end
        end
      end
      S_VEND: begin
        w_credit_nxt = r_credit - CREDIT_W'(PRICE);
        w_state_nxt  = (r_credit == CREDIT_W'(PRICE)) ? S_IDLE : S_CHANGE;
      end
      S_CHANGE: begin
        if (r_change_valid && bus.change_ack) begin
          w_credit_nxt = r_credit - w_chg_val;
          if (r_credit == w_chg_val) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_change_valid_nxt = (w_state_nxt == S_CHANGE);
    w_change_coin_nxt  = w_change_valid_nxt ? largest_coin(w_credit_nxt) : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_reject       <= 1'b0;
      r_dispense     <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_coin  <= 2'b00;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_reject       <= w_reject_nxt;
      r_dispense     <= w_dispense_nxt;
      r_change_valid <= w_change_valid_nxt;
      r_change_coin  <= w_change_coin_nxt;
    end
  end

`ifdef VM_STOCK_EN
  logic [STOCK_W-1:0] r_stock;
  logic               r_sold_out;

  // Decrement lands at the end of the VEND cycle; restock only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stock    <= STOCK_W'(STOCK_INIT);
      r_sold_out <= (STOCK_INIT == 0);
    end else if ((r_state == S_IDLE) && bus.restock) begin
      r_stock    <= STOCK_W'(STOCK_INIT);
      r_sold_out <= (STOCK_INIT == 0);
    end else if (r_dispense && (r_stock != '0)) begin
      r_stock    <= r_stock - STOCK_W'(1);
      r_sold_out <= (r_stock == STOCK_W'(1));
    end
  end

  assign w_sold_out = r_sold_out;
`else
  logic w_unused_stock;
  assign w_unused_stock = ^{bus.restock, STOCK_W'(STOCK_INIT)};
  assign w_sold_out     = 1'b0;
`endif

  assign bus.coin_ready   = w_coin_ready;
  assign bus.coin_reject  = r_reject;
  assign bus.dispense     = r_dispense;
  assign bus.change_valid = r_change_valid;
  assign bus.change_coin  = r_change_coin;
  assign bus.credit       = r_credit;
  assign bus.sold_out     = w_sold_out;

endmodule
